// File: rtl/sram_macro_ctrl.sv
// Valid/ready front end for a single-port synchronous SRAM macro with one-cycle read latency.
// Define SRAM_MACRO_CTRL_INIT_EN to zero-fill the macro after reset and expose init_done.
module sram_macro_ctrl #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
`ifdef SRAM_MACRO_CTRL_INIT_EN
    output logic              init_done,
`endif
    output logic              sram_CEB,
    output logic              sram_WEB,
    output logic [ADDR_W-1:0] sram_A,
    output logic [DATA_W-1:0] sram_D,
    input  logic [DATA_W-1:0] sram_Q
);

    logic              run;
    logic              accept;
    logic              rd_accept;
    logic              pending_q;
    logic [1:0]        occ;
    logic [1:0]        fifo_count_q, fifo_count_d;
    logic              rd_ptr_q, wr_ptr_q;
    logic [DATA_W-1:0] fifo_mem_q [2];
    logic              fifo_empty;
    logic              bypass;
    logic              push, pop;

`ifdef SRAM_MACRO_CTRL_INIT_EN
    typedef enum logic [1:0] {StIdle, StInit, StRun} state_e;
    state_e            state_q, state_d;
    logic [ADDR_W-1:0] init_addr_q, init_addr_d;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            init_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            init_addr_q <= init_addr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        init_addr_d = init_addr_q;
        unique case (state_q)
            StIdle: state_d = StInit;
            StInit: begin
                if (init_addr_q == ADDR_W'(DEPTH - 1)) begin
                    init_addr_d = '0;
                    state_d     = StRun;
                end else begin
                    init_addr_d = init_addr_q + 1'b1;
                end
            end
            StRun:   state_d = StRun;
            default: state_d = StIdle;
        endcase
    end

    assign run       = (state_q == StRun);
    assign init_done = run;
`else
    assign run = 1'b1;
`endif

    // Reads need a slot in pending+FIFO; a response popped this cycle frees nothing yet.
    assign occ        = {1'b0, pending_q} + fifo_count_q;
    assign req_ready  = reset_n & run & (req_write | (occ < 2'd2));
    assign accept     = req_valid & req_ready;
    assign rd_accept  = accept & ~req_write;

    always_comb begin
        sram_CEB = ~accept;
        sram_WEB = ~(accept & req_write);
        sram_A   = req_addr;
        sram_D   = req_wdata;
`ifdef SRAM_MACRO_CTRL_INIT_EN
        if (state_q == StInit) begin
            sram_CEB = 1'b0;
            sram_WEB = 1'b0;
            sram_A   = init_addr_q;
            sram_D   = '0;
        end
`endif
    end

    assign fifo_empty = (fifo_count_q == 2'd0);
    assign bypass     = pending_q & fifo_empty;
    assign resp_valid = bypass | ~fifo_empty;
    assign pop        = ~fifo_empty & resp_ready;
    assign push       = pending_q & ~(bypass & resp_ready);

    // sram_Q is only observed while pending_q marks its one valid cycle.
    always_comb begin
        resp_rdata = '0;
        if (bypass) begin
            resp_rdata = sram_Q;
        end else if (!fifo_empty) begin
            resp_rdata = fifo_mem_q[rd_ptr_q];
        end
    end

    assign fifo_count_d = fifo_count_q + 2'(push) - 2'(pop);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pending_q    <= 1'b0;
            fifo_count_q <= 2'd0;
            rd_ptr_q     <= 1'b0;
            wr_ptr_q     <= 1'b0;
        end else begin
            pending_q    <= rd_accept;
            fifo_count_q <= fifo_count_d;
            if (push) wr_ptr_q <= ~wr_ptr_q;
            if (pop)  rd_ptr_q <= ~rd_ptr_q;
        end
    end

    always_ff @(posedge clock) begin
        if (push) fifo_mem_q[wr_ptr_q] <= sram_Q;
    end

`ifndef SYNTHESIS
    always_ff @(posedge clock) begin
        if (reset_n) begin
            assert (fifo_count_q != 2'd3 && !(push && fifo_count_q == 2'd2))
            else $error("sram_macro_ctrl: response FIFO overflow (count=%0d push=%0b)",
                        fifo_count_q, push);
        end
    end
`endif

endmodule

// File: tb/tb_sram_macro_ctrl.sv
// Directed bench for sram_macro_ctrl with a behavioural single-port macro model.
module tb_sram_macro_ctrl;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        req_valid, req_ready, req_write;
    logic [7:0]  req_addr;
    logic [63:0] req_wdata;
    logic        resp_valid, resp_ready;
    logic [63:0] resp_rdata;
    logic        sram_CEB, sram_WEB;
    logic [7:0]  sram_A;
    logic [63:0] sram_D, sram_Q;
`ifdef SRAM_MACRO_CTRL_INIT_EN
    logic        init_done;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clock = ~clock;

    sram_macro_ctrl #(.DATA_W(64), .DEPTH(256), .ADDR_W(8)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
`ifdef SRAM_MACRO_CTRL_INIT_EN
        .init_done  (init_done),
`endif
        .sram_CEB   (sram_CEB),
        .sram_WEB   (sram_WEB),
        .sram_A     (sram_A),
        .sram_D     (sram_D),
        .sram_Q     (sram_Q)
    );

    // Macro model: Q holds read data only in the cycle after a read strobe, noise otherwise.
    logic [63:0] mem [256];
    logic [63:0] q_q;
    logic        q_vld = 1'b0;
    logic [63:0] junk = 64'h5A5A_5A5A_A5A5_A5A5;

    always @(posedge clock) begin
        junk  <= {$urandom, $urandom};
        q_vld <= !sram_CEB && sram_WEB;
        if (!sram_CEB) begin
            if (!sram_WEB) mem[sram_A] <= sram_D;
            else           q_q <= mem[sram_A];
        end
    end
    assign sram_Q = q_vld ? q_q : junk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic w, input logic [7:0] a, input logic [63:0] d);
        req_valid = v;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
    endtask

    task automatic wait_init();
`ifdef SRAM_MACRO_CTRL_INIT_EN
        int strobes = 0;
        int cyc = 0;
        do begin
            @(negedge clock);
            if (!init_done) begin
                if (!sram_CEB && !sram_WEB && sram_D == 64'd0) strobes++;
                check("init_ready_low", {63'd0, req_ready}, 64'd0);
            end
            cyc++;
        end while (!init_done && cyc < 400);
        check("init_strobes", 64'(strobes), 64'd256);
        check("init_done", {63'd0, init_done}, 64'd1);
        tick();
`endif
    endtask

    initial begin
        reset_n    = 1'b0;
        resp_ready = 1'b0;
        drive(1'b1, 1'b1, 8'h00, 64'h0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst_req_ready", {63'd0, req_ready}, 64'd0);
        check("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
        check("rst_ceb", {63'd0, sram_CEB}, 64'd1);
        check("rst_web", {63'd0, sram_WEB}, 64'd1);
        drive(1'b0, 1'b0, 8'h00, 64'h0);
        tick();
        reset_n = 1'b1;
        wait_init();

`ifdef SRAM_MACRO_CTRL_INIT_EN
        drive(1'b1, 1'b0, 8'hFF, 64'h0);
        resp_ready = 1'b1;
        tick();
        drive(1'b0, 1'b0, 8'h00, 64'h0);
        @(negedge clock);
        check("init_rd_ff", resp_rdata, 64'd0);
        tick();
`endif

        // Write then read back with consumer ready.
        drive(1'b1, 1'b1, 8'h05, 64'hDEADBEEF_01234567);
        @(negedge clock);
        check("wr_ready", {63'd0, req_ready}, 64'd1);
        check("wr_ceb", {63'd0, sram_CEB}, 64'd0);
        check("wr_web", {63'd0, sram_WEB}, 64'd0);
        check("wr_a", {56'd0, sram_A}, 64'h05);
        check("wr_d", sram_D, 64'hDEADBEEF_01234567);
        tick();
        drive(1'b1, 1'b0, 8'h05, 64'h0);
        resp_ready = 1'b1;
        @(negedge clock);
        check("rd_web", {63'd0, sram_WEB}, 64'd1);
        check("rd_no_early_valid", {63'd0, resp_valid}, 64'd0);
        tick();
        drive(1'b0, 1'b0, 8'h00, 64'h0);
        @(negedge clock);
        check("rd_valid", {63'd0, resp_valid}, 64'd1);
        check("rd_data", resp_rdata, 64'hDEADBEEF_01234567);
        tick();
        @(negedge clock);
        check("rd_valid_drop", {63'd0, resp_valid}, 64'd0);
        check("rd_no_leak", resp_rdata, 64'd0);
        tick();

        // Preload, then four back-to-back reads.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, 8'(8'h10 + i), 64'(16 + i));
            tick();
        end
        for (int k = 0; k < 5; k++) begin
            if (k < 4) drive(1'b1, 1'b0, 8'(8'h10 + k), 64'h0);
            else       drive(1'b0, 1'b0, 8'h00, 64'h0);
            @(negedge clock);
            if (k < 4) check("b2b_ready", {63'd0, req_ready}, 64'd1);
            if (k > 0) begin
                check("b2b_valid", {63'd0, resp_valid}, 64'd1);
                check("b2b_data", resp_rdata, 64'(16 + k - 1));
            end
            tick();
        end

        // Credit exhaustion with a stalled consumer.
        drive(1'b1, 1'b1, 8'h20, 64'h120);
        tick();
        drive(1'b1, 1'b1, 8'h21, 64'h121);
        tick();
        resp_ready = 1'b0;
        drive(1'b1, 1'b0, 8'h20, 64'h0);
        tick();
        drive(1'b1, 1'b0, 8'h21, 64'h0);
        @(negedge clock);
        check("cr_second_ready", {63'd0, req_ready}, 64'd1);
        check("cr_bypass_data", resp_rdata, 64'h120);
        tick();
        drive(1'b1, 1'b0, 8'h22, 64'h0);
        @(negedge clock);
        check("cr_third_blocked", {63'd0, req_ready}, 64'd0);
        check("cr_head_hold", resp_rdata, 64'h120);
        tick();
        resp_ready = 1'b1;
        @(negedge clock);
        check("cr_still_blocked", {63'd0, req_ready}, 64'd0);
        check("cr_first", resp_rdata, 64'h120);
        tick();
        drive(1'b0, 1'b0, 8'h00, 64'h0);
        @(negedge clock);
        check("cr_ready_back", {63'd0, req_ready}, 64'd1);
        check("cr_second", resp_rdata, 64'h121);
        tick();
        @(negedge clock);
        check("cr_drained", {63'd0, resp_valid}, 64'd0);
        tick();

        // Read-after-write, then a write with two reads outstanding.
        drive(1'b1, 1'b1, 8'h30, 64'hAA);
        tick();
        drive(1'b1, 1'b0, 8'h30, 64'h0);
        tick();
        drive(1'b0, 1'b0, 8'h00, 64'h0);
        @(negedge clock);
        check("raw_data", resp_rdata, 64'hAA);
        tick();
        resp_ready = 1'b0;
        drive(1'b1, 1'b0, 8'h30, 64'h0);
        tick();
        drive(1'b1, 1'b0, 8'h05, 64'h0);
        tick();
        drive(1'b1, 1'b1, 8'h31, 64'h55);
        @(negedge clock);
        check("wr_full_ready", {63'd0, req_ready}, 64'd1);
        check("wr_full_ceb", {63'd0, sram_CEB}, 64'd0);
        tick();
        drive(1'b0, 1'b0, 8'h00, 64'h0);
        resp_ready = 1'b1;
        @(negedge clock);
        check("wr_full_r0", resp_rdata, 64'hAA);
        tick();
        @(negedge clock);
        check("wr_full_r1", resp_rdata, 64'hDEADBEEF_01234567);
        tick();
        drive(1'b1, 1'b0, 8'h31, 64'h0);
        tick();
        drive(1'b0, 1'b0, 8'h00, 64'h0);
        @(negedge clock);
        check("wr_full_r2", resp_rdata, 64'h55);
        tick();

        // Reset with one pending read and one buffered response.
        resp_ready = 1'b0;
        drive(1'b1, 1'b0, 8'h10, 64'h0);
        tick();
        drive(1'b1, 1'b0, 8'h11, 64'h0);
        tick();
        drive(1'b1, 1'b1, 8'h40, 64'h77);
        #1;
        check("mid_pre_valid", {63'd0, resp_valid}, 64'd1);
        check("mid_pre_ceb", {63'd0, sram_CEB}, 64'd0);
        reset_n = 1'b0;
        #1;
        check("mid_valid_drop", {63'd0, resp_valid}, 64'd0);
        check("mid_ceb_high", {63'd0, sram_CEB}, 64'd1);
        check("mid_ready_low", {63'd0, req_ready}, 64'd0);
        drive(1'b0, 1'b0, 8'h00, 64'h0);
        tick();
        reset_n    = 1'b1;
        resp_ready = 1'b1;
        wait_init();
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("post_rst_no_stale", {63'd0, resp_valid}, 64'd0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
